vga_char_ctrl: RTL and testbench
================================

# vga_char_ctrl

Motion and colour controller for the VGA character-box renderer. Once per frame, during vertical blanking, it updates the character-box origin (`char_b_h`, `char_b_v`) and the glyph colour (`char_color`), so the text block bounces around the 640x480 active area. It sits beside the pixel generator, in the `vga_clk` domain, and watches the same `pix_x`/`pix_y` bus that the generator uses.

## Interface
- `H_VALID`, 10'd640: active width in pixels.
- `V_VALID`, 10'd480: active height in pixels.
- `CHAR_W`, 10'd256: character-box width.
- `CHAR_H`, 10'd64: character-box height.
- `INIT_H`, 10'd192: reset X origin.
- `INIT_V`, 10'd208: reset Y origin.
- `STEP`, 10'd4: pixels moved per move event, on each axis.
- `FRAME_DIV`, 8'd1: frames per move event; must be ≥1.
- `vga_clk` input 1: pixel clock; the only clock.
- `sys_rst` input 1: reset, synchronous, active-high.
- `pix_x` input 10: current pixel X; 10'h3FF outside the active area.
- `pix_y` input 10: current pixel Y; 10'h3FF outside the active area.
- `run` input 1: 1 = motion enabled, 0 = freeze the origin.
- `char_b_h` output 10: box X origin.
- `char_b_v` output 10: box Y origin.
- `char_color` output 16: RGB565 glyph colour.
- `bounce` output 1: one-cycle pulse in the cycle a wall hit is committed.

## Operation
- Frame tick: a registered pulse, high for one cycle after the cycle where `pix_x == H_VALID-1` and `pix_y == V_VALID-1` (the last active pixel).
- FSM states:
  - `S_IDLE`: enters `S_WAIT` when `run=1`.
  - `S_WAIT`: if `run=0`, goes to `S_IDLE`. On a tick, increments `div_cnt`. When `div_cnt == FRAME_DIV-1`, clears `div_cnt` and goes to `S_MOVE_X`.
  - `S_MOVE_X`: one cycle; commits X, then goes to `S_MOVE_Y`.
  - `S_MOVE_Y`: one cycle; commits Y and colour, then goes to `S_WAIT`.
- `run` is sampled only in `S_IDLE` and `S_WAIT`. A move sequence that has started always completes.
- X update, computed in 11 bits, with `XMAX = H_VALID-CHAR_W`:
  - `dir_x=+`: `nx = char_b_h + STEP`. If `nx >= XMAX`, set `char_b_h = XMAX` and flip `dir_x`. Otherwise `char_b_h = nx`.
  - `dir_x=-`: if `char_b_h <= STEP`, set `char_b_h = 0` and flip `dir_x`. Otherwise `char_b_h = char_b_h - STEP`.
  - The origin never underflows or exceeds `XMAX`.
- Y update: same rules with `YMAX = V_VALID-CHAR_H` and `dir_y`.
- `hit` flag: set in `S_MOVE_X` if X flipped; OR-ed in `S_MOVE_Y` if Y flipped.
  - At the end of `S_MOVE_Y`, if `hit=1`, pulse `bounce` and advance the colour once.
  - A corner hit (both axes flip in the same frame) gives one colour step and one `bounce` pulse.
- Outputs change only in the move states, which fall inside blanking, so no frame is ever drawn with a partially updated origin.
- Reset values, applied on the next edge with `sys_rst=1` from any state:
  - `char_b_h=INIT_H`, `char_b_v=INIT_V`
  - `dir_x=+`, `dir_y=+`
  - `char_color=16'hFEC0`, `bounce=0`
  - `div_cnt=0`, `hit=0`, palette index 0, state `S_IDLE`
- A reset in the middle of a move sequence abandons the partial update.

## Timing
- Let cycle T be the last active pixel. Then:
  - tick is high at T+1;
  - `S_MOVE_X` is active at T+2, and the new `char_b_h` is visible at T+3;
  - the new `char_b_v`, the new `char_color` and the `bounce` pulse are all visible at T+4.
- The worst-case path is the 11-bit add, compare and mux, all within one cycle.

## Configuration
- `VGA_CHAR_COLOR_CYCLE_EN` defined:
  - each `bounce` advances a 2-bit palette index: 0 = 16'hFEC0 (golden), 1 = 16'hFFFF (white), 2 = 16'hF800 (red), 3 = 16'h07E0 (green);
  - index 3 wraps to 0.
- Macro undefined:
  - `char_color` is constant 16'hFEC0;
  - no palette index register exists;
  - `bounce` still pulses.

## Structure
- Shared package `vga_pkg`:
  - RGB565 colour constants (BLACK, WHITE, GOLDEN, RED, GREEN);
  - the 640x480 active-area constants;
  - the FSM state encoding.
- One sub-module, `vga_frame_tick`: the last-pixel comparator plus pulse register. It is reusable by other per-frame controllers.

## Test plan
- Reset: hold `sys_rst=1` for 3 cycles -> `char_b_h=192`, `char_b_v=208`, `char_color=FEC0`, `bounce=0`.
- Run, right wall (`STEP=4`, `FRAME_DIV=1`, `run=1`):
  - after 1 frame, origin = (196, 212);
  - after 48 frames, `char_b_h=384`, `bounce` pulses and colour becomes FFFF (macro on);
  - at frame 49, `char_b_h=380`.
- Corner (`INIT_H=380`, `INIT_V=412`): one frame -> (384, 416), exactly one `bounce` pulse, colour FEC0→FFFF. Next frame -> (380, 412).
- Divider (`FRAME_DIV=3`): the origin changes only on every third tick. Ticks 1 and 2 leave (192, 208); tick 3 gives (196, 212).
- Freeze:
  - drop `run` at T+2 (in `S_MOVE_X`) -> the move still completes;
  - no further moves over the next 5 frames;
  - raising `run` again resumes motion from the held origin.
- Reset mid-move: assert `sys_rst` at T+3 -> outputs return to reset values at T+4 and `char_b_v` shows no partial update.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA character-box controllers.
//   - RGB565 colour constants
//   - 640x480 active-area constants
//   - FSM state encoding for vga_char_ctrl
//   - axis_next(): one bounded step of a bouncing coordinate
//   - palette(): glyph colour selected by a 2-bit palette index
package vga_pkg;

  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] GOLDEN = 16'hFEC0;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] GREEN  = 16'h07E0;

  localparam logic [9:0] VGA_H_VALID = 10'd640;
  localparam logic [9:0] VGA_V_VALID = 10'd480;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_MOVE_X = 2'd2,
    S_MOVE_Y = 2'd3
  } fsm_state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       flip;
  } axis_upd_t;

  // dir_neg = 0 moves towards max, 1 moves towards 0. The sum is taken in
  // 11 bits so a step past the top of the 10-bit range cannot wrap.
  function automatic axis_upd_t axis_next(input logic [9:0] pos,
                                          input logic       dir_neg,
                                          input logic [9:0] step,
                                          input logic [9:0] max);
    axis_upd_t  r;
    logic [10:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (!dir_neg) begin
      if (sum >= {1'b0, max}) r = '{pos: max, flip: 1'b1};
      else                    r = '{pos: sum[9:0], flip: 1'b0};
    end else begin
      if (pos <= step) r = '{pos: 10'd0, flip: 1'b1};
      else             r = '{pos: pos - step, flip: 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] palette(input logic [1:0] idx);
    case (idx)
      2'd0:    return GOLDEN;
      2'd1:    return WHITE;
      2'd2:    return RED;
      default: return GREEN;
    endcase
  endfunction

endpackage

// File: rtl/vga_char_ctrl_if.sv
// vga_char_ctrl_if: pixel-position bus in, box origin/colour out.
//   pix_x, pix_y : current pixel, 10'h3FF outside the active area
//   run          : 1 = motion enabled
//   char_b_h/v   : box origin
//   char_color   : RGB565 glyph colour
//   bounce       : one-cycle pulse when a wall hit is committed
//   state        : controller FSM state, for observation only
// Signalling: there is no valid/ready pair; pix_x/pix_y/run are sampled every
// vga_clk edge, outputs are registered and change only in the two move
// states, and bounce is high for exactly one cycle per committed hit.
// master = pixel-timing side, slave = vga_char_ctrl.
interface vga_char_ctrl_if;
  logic [9:0]          pix_x;
  logic [9:0]          pix_y;
  logic                run;
  logic [9:0]          char_b_h;
  logic [9:0]          char_b_v;
  logic [15:0]         char_color;
  logic                bounce;
  vga_pkg::fsm_state_t state;

  modport master (
    output pix_x, pix_y, run,
    input  char_b_h, char_b_v, char_color, bounce, state
  );

  modport slave (
    input  pix_x, pix_y, run,
    output char_b_h, char_b_v, char_color, bounce, state
  );
endinterface

// File: rtl/vga_frame_tick.sv
// vga_frame_tick: one-cycle registered pulse in the cycle after the last
// active pixel (pix_x == H_VALID-1, pix_y == V_VALID-1).
//   vga_clk : pixel clock
//   sys_rst : synchronous active-high reset
//   pix_x/y : current pixel position
//   tick    : frame pulse
module vga_frame_tick
  import vga_pkg::*;
#(
  parameter logic [9:0] H_VALID = VGA_H_VALID,
  parameter logic [9:0] V_VALID = VGA_V_VALID
) (
  input  logic       vga_clk,
  input  logic       sys_rst,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       tick
);

  always_ff @(posedge vga_clk) begin
    if (sys_rst) tick <= 1'b0;
    else         tick <= (pix_x == H_VALID - 10'd1) && (pix_y == V_VALID - 10'd1);
  end

endmodule

// File: rtl/vga_char_ctrl.sv
// vga_char_ctrl: once per FRAME_DIV frames, during vertical blanking, moves
// the character-box origin by STEP on each axis and bounces it off the
// edges of the active area.
//   vga_clk : pixel clock (only clock)
//   sys_rst : synchronous active-high reset
//   bus     : vga_char_ctrl_if.slave (pixel bus, run, origin/colour/bounce, state)
// Build option VGA_CHAR_COLOR_CYCLE_EN: each bounce advances a 2-bit palette
// index (golden, white, red, green). Without it the colour stays golden.
module vga_char_ctrl
  import vga_pkg::*;
#(
  parameter logic [9:0] H_VALID   = VGA_H_VALID,
  parameter logic [9:0] V_VALID   = VGA_V_VALID,
  parameter logic [9:0] CHAR_W    = 10'd256,
  parameter logic [9:0] CHAR_H    = 10'd64,
  parameter logic [9:0] INIT_H    = 10'd192,
  parameter logic [9:0] INIT_V    = 10'd208,
  parameter logic [9:0] STEP      = 10'd4,
  parameter logic [7:0] FRAME_DIV = 8'd1
) (
  input logic           vga_clk,
  input logic           sys_rst,
  vga_char_ctrl_if.slave bus
);

  localparam logic [9:0] XMAX = H_VALID - CHAR_W;
  localparam logic [9:0] YMAX = V_VALID - CHAR_H;

  logic       tick;
  fsm_state_t state;
  logic [7:0] div_cnt;
  logic [9:0] char_b_h;
  logic [9:0] char_b_v;
  logic       dir_x;
  logic       dir_y;
  logic       hit;
  logic       bounce;
  logic [15:0] char_color;
  axis_upd_t  upd_x;
  axis_upd_t  upd_y;

`ifdef VGA_CHAR_COLOR_CYCLE_EN
  logic [1:0] pal_idx;
`else
  assign char_color = GOLDEN;
`endif

  vga_frame_tick #(
    .H_VALID (H_VALID),
    .V_VALID (V_VALID)
  ) u_tick (
    .vga_clk (vga_clk),
    .sys_rst (sys_rst),
    .pix_x   (bus.pix_x),
    .pix_y   (bus.pix_y),
    .tick    (tick)
  );

  assign upd_x = axis_next(char_b_h, dir_x, STEP, XMAX);
  assign upd_y = axis_next(char_b_v, dir_y, STEP, YMAX);

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state    <= S_IDLE;
      div_cnt  <= 8'd0;
      char_b_h <= INIT_H;
      char_b_v <= INIT_V;
      dir_x    <= 1'b0;
      dir_y    <= 1'b0;
      hit      <= 1'b0;
      bounce   <= 1'b0;
`ifdef VGA_CHAR_COLOR_CYCLE_EN
      pal_idx    <= 2'd0;
      char_color <= GOLDEN;
`endif
    end else begin
      bounce <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.run) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.run) begin
            state   <= S_IDLE;
            div_cnt <= 8'd0;
          end else if (tick) begin
            if (div_cnt == FRAME_DIV - 8'd1) begin
              div_cnt <= 8'd0;
              state   <= S_MOVE_X;
            end else begin
              div_cnt <= div_cnt + 8'd1;
            end
          end
        end
        S_MOVE_X: begin
          char_b_h <= upd_x.pos;
          if (upd_x.flip) dir_x <= ~dir_x;
          hit   <= upd_x.flip;
          state <= S_MOVE_Y;
        end
        S_MOVE_Y: begin
          char_b_v <= upd_y.pos;
          if (upd_y.flip) dir_y <= ~dir_y;
          hit <= hit | upd_y.flip;
          // A corner hit flips both axes but counts as one bounce.
          if (hit | upd_y.flip) begin
            bounce <= 1'b1;
`ifdef VGA_CHAR_COLOR_CYCLE_EN
            pal_idx    <= pal_idx + 2'd1;
            char_color <= palette(pal_idx + 2'd1);
`endif
          end
          state <= S_WAIT;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.char_b_h   = char_b_h;
  assign bus.char_b_v   = char_b_v;
  assign bus.char_color = char_color;
  assign bus.bounce     = bounce;
  assign bus.state      = state;

endmodule

// File: tb/tb_vga_char_ctrl.sv
// tb_vga_char_ctrl: three controller instances share one pixel bus
//   0: default parameters
//   1: corner start, INIT_H=380 INIT_V=412
//   2: FRAME_DIV=3
// Stimulus pushes the expected snapshot {sel,h,v,colour,bounces} and raises
// chk_req; the monitor pops and compares on the following negedge.
module tb_vga_char_ctrl;

  localparam int W = 42;
`ifdef VGA_CHAR_COLOR_CYCLE_EN
  localparam logic [15:0] CW = 16'hFFFF;
`else
  localparam logic [15:0] CW = 16'hFEC0;
`endif
  localparam logic [15:0] GOLD = 16'hFEC0;

  logic clk;
  logic rst_m, rst_o;
  logic [9:0] pix_x, pix_y;
  logic run_m, run_c, run_d;
  logic chk_req;

  logic [W-1:0] exp_q[$];
  int total, bad, chk_id;
  int bcnt[3];

  vga_char_ctrl_if if_m ();
  vga_char_ctrl_if if_c ();
  vga_char_ctrl_if if_d ();

  assign if_m.pix_x = pix_x;  assign if_m.pix_y = pix_y;  assign if_m.run = run_m;
  assign if_c.pix_x = pix_x;  assign if_c.pix_y = pix_y;  assign if_c.run = run_c;
  assign if_d.pix_x = pix_x;  assign if_d.pix_y = pix_y;  assign if_d.run = run_d;

  vga_char_ctrl u_main (.vga_clk(clk), .sys_rst(rst_m), .bus(if_m));
  vga_char_ctrl #(.INIT_H(10'd380), .INIT_V(10'd412)) u_corner (.vga_clk(clk), .sys_rst(rst_o), .bus(if_c));
  vga_char_ctrl #(.FRAME_DIV(8'd3)) u_div (.vga_clk(clk), .sys_rst(rst_o), .bus(if_d));

  logic [9:0]  h_a[3];
  logic [9:0]  v_a[3];
  logic [15:0] c_a[3];
  logic        b_a[3];
  assign h_a[0] = if_m.char_b_h;  assign v_a[0] = if_m.char_b_v;
  assign c_a[0] = if_m.char_color; assign b_a[0] = if_m.bounce;
  assign h_a[1] = if_c.char_b_h;  assign v_a[1] = if_c.char_b_v;
  assign c_a[1] = if_c.char_color; assign b_a[1] = if_c.bounce;
  assign h_a[2] = if_d.char_b_h;  assign v_a[2] = if_d.char_b_v;
  assign c_a[2] = if_d.char_color; assign b_a[2] = if_d.bounce;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s chk=%0d got=%0h want=%0h", name, chk_id, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    int sel;
    for (int i = 0; i < 3; i++) if (b_a[i]) bcnt[i]++;
    if (chk_req) begin
      chk_id++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL queue_empty chk=%0d got=0 want=1", chk_id);
      end else begin
        e   = exp_q.pop_front();
        sel = int'(e[41:40]);
        cmp("char_b_h",   int'(h_a[sel]), int'(e[39:30]));
        cmp("char_b_v",   int'(v_a[sel]), int'(e[29:20]));
        cmp("char_color", int'(c_a[sel]), int'(e[19:4]));
        cmp("bounce_cnt", bcnt[sel],      int'(e[3:0]));
        bcnt[sel] = 0;
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_chk(input logic [1:0] sel, input logic [9:0] h, input logic [9:0] v,
                          input logic [15:0] c, input logic [3:0] b);
    exp_q.push_back({sel, h, v, c, b});
    chk_req = 1'b1;
    step(1);
    chk_req = 1'b0;
  endtask

  // One last-active-pixel cycle; returns just after the edge that samples it.
  task automatic frame();
    pix_x = 10'd639;
    pix_y = 10'd479;
    step(1);
    pix_x = 10'h3FF;
    pix_y = 10'h3FF;
  endtask

  // stimulus
  initial begin
    total = 0; bad = 0; chk_id = 0;
    for (int i = 0; i < 3; i++) bcnt[i] = 0;
    chk_req = 1'b0;
    pix_x = 10'h3FF; pix_y = 10'h3FF;
    run_m = 1'b0; run_c = 1'b0; run_d = 1'b0;
    rst_m = 1'b1; rst_o = 1'b1;
    step(3);
    push_chk(2'd0, 10'd192, 10'd208, GOLD, 4'd0);
    push_chk(2'd1, 10'd380, 10'd412, GOLD, 4'd0);
    push_chk(2'd2, 10'd192, 10'd208, GOLD, 4'd0);
    rst_m = 1'b0; rst_o = 1'b0;

    // right wall run on instance 0
    run_m = 1'b1;
    step(2);
    frame();
    step(2);
    push_chk(2'd0, 10'd196, 10'd208, GOLD, 4'd0);  // T+3: X committed, Y not yet
    step(1);
    push_chk(2'd0, 10'd196, 10'd212, GOLD, 4'd0);  // T+4/5: full update
    for (int k = 2; k <= 47; k++) begin
      frame();
      step(4);
      push_chk(2'd0, 10'(192 + 4 * k), 10'(208 + 4 * k), GOLD, 4'd0);
    end
    frame(); step(4);
    push_chk(2'd0, 10'd384, 10'd400, CW, 4'd1);
    frame(); step(4);
    push_chk(2'd0, 10'd380, 10'd404, CW, 4'd0);

    // reset in the middle of a move sequence
    frame();
    step(2);
    rst_m = 1'b1;
    step(1);
    push_chk(2'd0, 10'd192, 10'd208, GOLD, 4'd0);
    rst_m = 1'b0;
    step(2);

    // freeze: drop run while in S_MOVE_X
    frame();
    step(1);
    run_m = 1'b0;
    step(3);
    push_chk(2'd0, 10'd196, 10'd212, GOLD, 4'd0);
    for (int k = 0; k < 5; k++) begin
      frame(); step(4);
      push_chk(2'd0, 10'd196, 10'd212, GOLD, 4'd0);
    end
    run_m = 1'b1;
    step(2);
    frame(); step(4);
    push_chk(2'd0, 10'd200, 10'd216, GOLD, 4'd0);
    run_m = 1'b0;

    // corner hit on instance 1
    run_c = 1'b1;
    step(2);
    frame(); step(4);
    push_chk(2'd1, 10'd384, 10'd416, CW, 4'd1);
    frame(); step(4);
    push_chk(2'd1, 10'd380, 10'd412, CW, 4'd0);
    run_c = 1'b0;

    // frame divider on instance 2
    run_d = 1'b1;
    step(2);
    frame(); step(4);
    push_chk(2'd2, 10'd192, 10'd208, GOLD, 4'd0);
    frame(); step(4);
    push_chk(2'd2, 10'd192, 10'd208, GOLD, 4'd0);
    frame(); step(4);
    push_chk(2'd2, 10'd196, 10'd212, GOLD, 4'd0);

    step(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
